// File: rtl/seq_pkg.sv
// Shared definitions for the sequence checker.
// The generator under test cycles through six 4-bit codes:
//    0 -> 8 -> 5 -> 3 -> 7 -> 2 -> 0 ...
// Code 2 is the last code of a period.
package seq_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   localparam int SEQ_LEN = 6;

   localparam logic [3:0] SEQ0 = 4'd0;
   localparam logic [3:0] SEQ1 = 4'd8;
   localparam logic [3:0] SEQ2 = 4'd5;
   localparam logic [3:0] SEQ3 = 4'd3;
   localparam logic [3:0] SEQ4 = 4'd7;
   localparam logic [3:0] SEQ5 = 4'd2;

   localparam logic [3:0] LAST_CODE = SEQ5;

endpackage

// File: rtl/seq_next.sv
// Successor lookup for the generator sequence.
// Ports:
//    code   in   4  code to look up
//    nxt    out  4  code that follows 'code' in the cycle (0 when illegal)
//    legal  out  1  'code' is one of the six sequence codes
module seq_next
   import seq_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] nxt,
   output logic       legal
);

   always_comb begin
      nxt   = 4'd0;
      legal = 1'b1;
      case (code)
         SEQ0:    nxt = SEQ1;
         SEQ1:    nxt = SEQ2;
         SEQ2:    nxt = SEQ3;
         SEQ3:    nxt = SEQ4;
         SEQ4:    nxt = SEQ5;
         SEQ5:    nxt = SEQ0;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/sequence_checker.sv
// Checks a sampled generator stream against the fixed code cycle, acquiring
// lock after LOCK_COUNT correct transitions and flywheeling through isolated
// mismatches until UNLOCK_ERRS consecutive misses drop lock.
// Ports:
//    clock         in   1      system clock, posedge
//    reset         in   1      synchronous, active-high
//    valid         in   1      data_in sampled when high
//    data_in       in   4      generator output under check
//    locked        out  1      high while LOCKED
//    error         out  1      pulse: mismatch while LOCKED
//    illegal       out  1      pulse: sampled code outside the sequence
//    expected      out  4      code expected at the next valid sample
//    period_done   out  1      pulse: last code matched while LOCKED
//    err_count     out  CNT_W  saturating mismatch count while LOCKED
//    period_count  out  CNT_W  completed periods, wrapping
//
// state   | meaning
// HUNT    | no reference; waiting for any legal code to seed 'expected'
// ACQUIRE | seeded; counting consecutive correct transitions toward lock
// LOCKED  | tracking; mismatches are flagged and 'expected' free-runs
module sequence_checker
   import seq_pkg::*;
#(
   parameter int LOCK_COUNT  = 3,
   parameter int UNLOCK_ERRS = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid,
   input  logic [3:0]       data_in,
   output logic             locked,
   output logic             error,
   output logic             illegal,
   output logic [3:0]       expected,
   output logic             period_done,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] period_count
);

   localparam logic [3:0] LOCK_TC   = 4'(LOCK_COUNT);
   localparam logic [3:0] UNLOCK_TC = 4'(UNLOCK_ERRS);

   state_e           state_q, state_d;
   logic [3:0]       expected_q, expected_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic [3:0]       miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] period_count_q, period_count_d;
   logic             error_q, error_d;
   logic             illegal_q, illegal_d;
   logic             period_done_q, period_done_d;

   logic [3:0] data_nxt, exp_nxt;
   logic       data_legal, exp_legal;
   logic [3:0] match_inc, miss_inc;

   // Data path: successor of the sampled code, used while seeding/acquiring.
   seq_next u_next_data (
      .code  (data_in),
      .nxt   (data_nxt),
      .legal (data_legal)
   );

   // Flywheel path: successor of what we expected, used while locked so a
   // corrupted sample does not disturb the phase reference.
   seq_next u_next_fly (
      .code  (expected_q),
      .nxt   (exp_nxt),
      .legal (exp_legal)
   );

   assign match_inc = match_cnt_q + 4'd1;
   assign miss_inc  = miss_cnt_q + 4'd1;

   always_comb begin
      state_d        = state_q;
      expected_d     = expected_q;
      match_cnt_d    = match_cnt_q;
      miss_cnt_d     = miss_cnt_q;
      err_count_d    = err_count_q;
      period_count_d = period_count_q;
      error_d        = 1'b0;
      illegal_d      = 1'b0;
      period_done_d  = 1'b0;

      if (valid) begin
         case (state_q)
            HUNT: begin
               if (data_legal) begin
                  expected_d  = data_nxt;
                  match_cnt_d = 4'd0;
                  state_d     = ACQUIRE;
               end else begin
                  illegal_d = 1'b1;
               end
            end

            ACQUIRE: begin
               if (!data_legal) begin
                  illegal_d   = 1'b1;
                  expected_d  = 4'd0;
                  match_cnt_d = 4'd0;
                  state_d     = HUNT;
               end else if (data_in == expected_q) begin
                  expected_d  = data_nxt;
                  match_cnt_d = match_inc;
                  if (match_inc == LOCK_TC) begin
                     miss_cnt_d = 4'd0;
                     state_d    = LOCKED;
                  end
               end else begin
                  expected_d  = data_nxt;
                  match_cnt_d = 4'd0;
               end
            end

            LOCKED: begin
               if (exp_legal && data_in == expected_q) begin
                  expected_d = exp_nxt;
                  miss_cnt_d = 4'd0;
                  if (data_in == LAST_CODE) begin
                     period_done_d  = 1'b1;
                     period_count_d = period_count_q + CNT_W'(1);
                  end
               end else begin
                  error_d   = 1'b1;
                  illegal_d = !data_legal;
                  if (!(&err_count_q)) err_count_d = err_count_q + CNT_W'(1);
                  if (miss_inc == UNLOCK_TC) begin
                     expected_d  = 4'd0;
                     miss_cnt_d  = 4'd0;
                     match_cnt_d = 4'd0;
                     state_d     = HUNT;
                  end else begin
                     expected_d = exp_nxt;
                     miss_cnt_d = miss_inc;
                  end
               end
            end

            default: begin
               expected_d  = 4'd0;
               match_cnt_d = 4'd0;
               miss_cnt_d  = 4'd0;
               state_d     = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= HUNT;
         expected_q     <= 4'd0;
         match_cnt_q    <= 4'd0;
         miss_cnt_q     <= 4'd0;
         err_count_q    <= '0;
         period_count_q <= '0;
         error_q        <= 1'b0;
         illegal_q      <= 1'b0;
         period_done_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         expected_q     <= expected_d;
         match_cnt_q    <= match_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
         err_count_q    <= err_count_d;
         period_count_q <= period_count_d;
         error_q        <= error_d;
         illegal_q      <= illegal_d;
         period_done_q  <= period_done_d;
      end
   end

   assign locked       = (state_q == LOCKED);
   assign error        = error_q;
   assign illegal      = illegal_q;
   assign expected     = expected_q;
   assign period_done  = period_done_q;
   assign err_count    = err_count_q;
   assign period_count = period_count_q;

endmodule
